// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 size codes
// and the access FSM state encoding.
package mem_stage_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Picks the byte/halfword addressed inside a read word and sign- or
// zero-extends it according to funct3.
module load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Bring the addressed lane down to bit 0 before extending.
  assign shifted = rdata >> {addr, 3'b000};

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  data = {24'd0, shifted[7:0]};
      F3_LHU:  data = {16'd0, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: fault detection, store lane/strobe generation,
// req/ready bus handshake FSM and the registered load result.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic [2:0]        funct3_m,
  input  logic [ADDR_W-1:0] alu_result_m,
  input  logic [31:0]       write_data_m,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata,
  output logic [31:0]       read_data_m,
  output logic              stall_m,
  output logic              fault_m
);

  lsu_state_e  state_reg, state_next;
  logic [31:0] read_data_reg;
  logic [31:0] load_value;
  logic [1:0]  size;
  logic        access, illegal_f3, misaligned, load_done;

  assign access = mem_read_m | mem_write_m;
  assign size   = funct3_m[1:0];

  assign illegal_f3 = (funct3_m == 3'b011) || (funct3_m[2:1] == 2'b11) ||
                      (mem_write_m && funct3_m[2]);
  assign misaligned = ((size == 2'b01) && alu_result_m[0]) ||
                      ((size == 2'b10) && (alu_result_m[1:0] != 2'b00));
  assign fault_m    = access && (illegal_f3 || misaligned || (mem_read_m && mem_write_m));

  assign bus_we   = mem_write_m;
  assign bus_addr = {alu_result_m[ADDR_W-1:2], 2'b00};

  always_comb begin
    bus_wstrb = 4'b0000;
    if (mem_write_m) begin
      case (size)
        2'b00:   bus_wstrb = 4'b0001 << alu_result_m[1:0];
        2'b01:   bus_wstrb = 4'b0011 << {alu_result_m[1], 1'b0};
        default: bus_wstrb = 4'b1111;
      endcase
    end
  end

  // Replicate the store data across lanes so the strobe alone selects the target.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign bus_wdata[gi*8 +: 8] = (size == 2'b00) ? write_data_m[7:0] :
                                  (size == 2'b01) ? write_data_m[(gi%2)*8 +: 8] :
                                                    write_data_m[gi*8 +: 8];
  end

  load_align u_load_align (
    .rdata  (bus_rdata),
    .addr   (alu_result_m[1:0]),
    .funct3 (funct3_m),
    .data   (load_value)
  );

  assign load_done = (state_reg == ACCESS) && bus_ready && mem_read_m;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      read_data_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (load_done)
        read_data_reg <= load_value;
    end
  end

  assign read_data_m = read_data_reg;

  // DONE never starts a new access: the finished instruction is still in MEM.
  always_comb begin
    state_next = state_reg;
    bus_req    = 1'b0;
    stall_m    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (access && !fault_m) begin
          stall_m    = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        bus_req = 1'b1;
        stall_m = 1'b1;
        if (bus_ready)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: expected load results are queued when an
// access is driven and compared when the unit reaches DONE.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_m, mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, write_data_m;
  logic        bus_req, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, read_data_m;
  logic [3:0]  bus_wstrb;
  logic        stall_m, fault_m;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] rd_model = 32'd0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_m   (mem_read_m),
    .mem_write_m  (mem_write_m),
    .funct3_m     (funct3_m),
    .alu_result_m (alu_result_m),
    .write_data_m (write_data_m),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_ready    (bus_ready),
    .bus_rdata    (bus_rdata),
    .read_data_m  (read_data_m),
    .stall_m      (stall_m),
    .fault_m      (fault_m)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    mem_read_m   = 1'b0;
    mem_write_m  = 1'b0;
    funct3_m     = 3'b010;
    alu_result_m = 32'd0;
    write_data_m = 32'd0;
    bus_ready    = 1'b0;
    bus_rdata    = 32'd0;
  endtask

  // Called just after a rising edge with the unit in IDLE.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] word, input int ws,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                           input logic [31:0] exp_load);
    int stalls = 0;
    logic [31:0] exp;
    mem_read_m   = rd;
    mem_write_m  = wr;
    funct3_m     = f3;
    alu_result_m = addr;
    write_data_m = wd;
    bus_ready    = 1'b1;
    bus_rdata    = 32'hBAD0_BAD0;
    if (rd) begin
      exp_q.push_back(exp_load);
      rd_model = exp_load;
    end else begin
      exp_q.push_back(rd_model);
    end
    #1;
    check_eq("idle_stall", 32'(stall_m), 32'd1);
    check_eq("idle_req", 32'(bus_req), 32'd0);
    check_eq("fault", 32'(fault_m), 32'd0);
    check_eq("bus_addr", bus_addr, {addr[31:2], 2'b00});
    check_eq("bus_we", 32'(bus_we), 32'(wr));
    check_eq("bus_wstrb", 32'(bus_wstrb), 32'(exp_strb));
    if (wr) check_eq("bus_wdata", bus_wdata, exp_wdata);
    stalls += int'(stall_m);
    bus_ready = 1'b0;
    for (int c = 0; c <= ws; c++) begin
      @(posedge clk); #1;
      check_eq("access_req", 32'(bus_req), 32'd1);
      stalls += int'(stall_m);
      bus_ready = (c == ws);
      bus_rdata = (c == ws) ? word : 32'h5555_AAAA;
    end
    @(posedge clk); #1;
    check_eq("done_req", 32'(bus_req), 32'd0);
    check_eq("done_stall", 32'(stall_m), 32'd0);
    stalls += int'(stall_m);
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check_eq("read_data", read_data_m, exp);
    end
    check_eq("stall_cycles", stalls, ws + 2);
    bus_ready = 1'b1;
    bus_rdata = 32'hDEAD_0BAD;
    @(posedge clk); #1;
    drive_idle();
    #1;
    check_eq("idle_hold", read_data_m, rd_model);
    check_eq("idle_req_after", 32'(bus_req), 32'd0);
    $display("access rd=%0b wr=%0b f3=%03b addr=0x%08h ws=%0d read_data=0x%08h stalls=%0d",
             rd, wr, f3, addr, ws, read_data_m, stalls);
  endtask

  task automatic do_fault(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr);
    mem_read_m   = rd;
    mem_write_m  = wr;
    funct3_m     = f3;
    alu_result_m = addr;
    write_data_m = 32'hCAFE_F00D;
    bus_ready    = 1'b1;
    bus_rdata    = 32'h7777_7777;
    #1;
    check_eq("fault_flag", 32'(fault_m), 32'd1);
    check_eq("fault_req", 32'(bus_req), 32'd0);
    check_eq("fault_stall", 32'(stall_m), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check_eq("fault_req_hold", 32'(bus_req), 32'd0);
      check_eq("fault_stall_hold", 32'(stall_m), 32'd0);
      check_eq("fault_read_data", read_data_m, rd_model);
    end
    $display("fault rd=%0b wr=%0b f3=%03b addr=0x%08h fault_m=%0b", rd, wr, f3, addr, fault_m);
    drive_idle();
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return 32'($signed(b));
      3'b001:  return 32'($signed(h));
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return w;
    endcase
  endfunction

  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_read_data", read_data_m, 32'd0);
    check_eq("rst_req", 32'(bus_req), 32'd0);
    check_eq("rst_stall", 32'(stall_m), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_access(1, 0, 3'b010, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 0, 32'd0, 4'b0000, 32'hDEAD_BEEF);
    do_access(1, 0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_0000, 0, 32'd0, 4'b0000, 32'hFFFF_FF80);
    do_access(1, 0, 3'b100, 32'h0000_1003, 32'd0, 32'h80FF_0000, 1, 32'd0, 4'b0000, 32'h0000_0080);
    do_access(1, 0, 3'b001, 32'h0000_1002, 32'd0, 32'h80FF_0000, 0, 32'd0, 4'b0000, 32'hFFFF_80FF);
    do_access(1, 0, 3'b101, 32'h0000_1000, 32'd0, 32'h80FF_9234, 0, 32'd0, 4'b0000, 32'h0000_9234);
    do_access(0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 0, 32'hABCD_ABCD, 4'b1100, 32'd0);
    do_access(0, 1, 3'b000, 32'h0000_2001, 32'h0000_005A, 32'd0, 2, 32'h5A5A_5A5A, 4'b0010, 32'd0);
    do_access(0, 1, 3'b010, 32'h0000_2004, 32'h0102_0304, 32'd0, 0, 32'h0102_0304, 4'b1111, 32'd0);
    do_access(1, 0, 3'b010, 32'h0000_3000, 32'd0, 32'h1357_9BDF, 3, 32'd0, 4'b0000, 32'h1357_9BDF);

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, w;
      case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      a = $urandom;
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      w = $urandom;
      do_access(1, 0, f3, a, 32'd0, w, $urandom_range(0, 2), 32'd0, 4'b0000, ref_load(f3, a[1:0], w));
    end

    do_fault(1, 0, 3'b010, 32'h0000_1002);
    do_fault(0, 1, 3'b101, 32'h0000_2000);
    do_fault(1, 0, 3'b001, 32'h0000_1001);
    do_fault(1, 0, 3'b011, 32'h0000_1000);
    do_fault(1, 1, 3'b010, 32'h0000_1000);

    // Reset in the second ACCESS cycle, then a late bus_ready.
    mem_read_m   = 1'b1;
    funct3_m     = 3'b010;
    alu_result_m = 32'h0000_1008;
    #1;
    @(posedge clk); #1;
    check_eq("rst_mid_req1", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    check_eq("rst_mid_req2", 32'(bus_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rd_model = 32'd0;
    mem_read_m = 1'b0;
    bus_ready  = 1'b1;
    bus_rdata  = 32'h1234_5678;
    #1;
    check_eq("rst_mid_req_drop", 32'(bus_req), 32'd0);
    check_eq("rst_mid_stall", 32'(stall_m), 32'd0);
    check_eq("rst_mid_read_data", read_data_m, 32'd0);
    @(posedge clk); #1;
    check_eq("late_ready_req", 32'(bus_req), 32'd0);
    check_eq("late_ready_read_data", read_data_m, 32'd0);
    $display("reset mid-access: bus_req=%0b read_data=0x%08h", bus_req, read_data_m);
    drive_idle();
    @(posedge clk); #1;

    do_access(1, 0, 3'b000, 32'h0000_4002, 32'd0, 32'h007F_0000, 0, 32'd0, 4'b0000, 32'h0000_007F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
